bus_scheduler: RTL and testbench

Time-division scheduler for the shared system bus (17-bit address, 8-bit data, RAM strobes). Splits each 1 MHz CPU cycle into 16 slots of 16 MHz: video RAM fetch, video ROM fetch, one RPi (SPI bridge) access, and the 6502 phase. Generates phi2, clk8 and all per-requester select/strobe signals consumed by top-level address decoding and RAM enables. When the CPU is halted (RDY low), a second RPi slot is granted in the CPU phase.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_sched_checker.sv | 13 +
 rtl/bus_slot_counter.sv | 59 +++++
 rtl/bus_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_bus_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared slot positions and RPi access states for the bus scheduler.
// Slot numbers are positions within the 16-slot frame.
package bus_pkg;

   localparam logic [3:0] CYC_VID_RAM  = 4'd0;
   localparam logic [3:0] CYC_VID_ROM  = 4'd2;
   localparam logic [3:0] CYC_PI_SLOT0 = 4'd5;
   localparam logic [3:0] CYC_CPU      = 4'd8;
   localparam logic [3:0] CYC_PI_SLOT1 = 4'd12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } pi_state_t;

endpackage

// File: rtl/bus_sched_checker.sv
// Bus ownership checker: at most one requester may own the bus in any cycle.
module bus_sched_checker (
   input logic i_clk,
   input logic i_rst_n,
   input logic i_video_sel,
   input logic i_pi_sel,
   input logic i_cpu_en
);

   a_single_owner: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $onehot0({i_video_sel, i_pi_sel, i_cpu_en}));

endmodule

// File: rtl/bus_slot_counter.sv
// Frame slot counter with clk8/phi2 generation and per-frame flag sampling.
// The *_nxt outputs describe the slot that starts at the coming clock edge.
module bus_slot_counter (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_video_en,
   input  logic       i_cpu_halted,
   output logic [3:0] o_cyc_nxt,
   output logic       o_video_frame_nxt,
   output logic       o_halted_frame_nxt,
   output logic       o_clk8,
   output logic       o_phi2
);

   logic [3:0] r_cyc;
   logic       r_video_flag;
   logic       r_halted_flag;
   logic       r_clk8;
   logic       r_phi2;
   logic [3:0] w_cyc_nxt;
   logic       w_video_nxt;
   logic       w_halted_nxt;

   // Next slot number and frame flags, which only change across the 15->0 wrap.
   always_comb begin
      w_cyc_nxt = r_cyc + 4'd1;
      if (r_cyc == 4'd15) begin
         w_video_nxt  = i_video_en;
         w_halted_nxt = i_cpu_halted;
      end else begin
         w_video_nxt  = r_video_flag;
         w_halted_nxt = r_halted_flag;
      end
   end

   // Counter, flags and derived clocks.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cyc         <= 4'd0;
         r_video_flag  <= 1'b0;
         r_halted_flag <= 1'b0;
         r_clk8        <= 1'b0;
         r_phi2        <= 1'b0;
      end else begin
         r_cyc         <= w_cyc_nxt;
         r_video_flag  <= w_video_nxt;
         r_halted_flag <= w_halted_nxt;
         r_clk8        <= w_cyc_nxt[0];
         r_phi2        <= w_cyc_nxt[3];
      end
   end

   assign o_cyc_nxt          = w_cyc_nxt;
   assign o_video_frame_nxt  = w_video_nxt;
   assign o_halted_frame_nxt = w_halted_nxt;
   assign o_clk8             = r_clk8;
   assign o_phi2             = r_phi2;

endmodule

// File: rtl/bus_scheduler.sv
// Time-division bus scheduler: video fetch, RPi access and 6502 phase per 1 MHz frame.
// Every output is decoded one slot ahead and registered.
module bus_scheduler
   import bus_pkg::*;
#(
   parameter bit VIDEO_EN_DEFAULT = 1'b1,
   parameter bit PI_TURBO         = 1'b1
) (
   input  logic clk_sys_i,
   input  logic reset_ni,
   input  logic video_en_i,
   input  logic cpu_halted_i,
   input  logic bus_rw_ni,
   input  logic pi_pending_i,
   input  logic pi_rw_ni,
   output logic clk8_o,
   output logic phi2_o,
   output logic cpu_enable_o,
   output logic cpu_read_o,
   output logic cpu_write_o,
   output logic video_select_o,
   output logic video_ram_strobe_o,
   output logic video_rom_strobe_o,
   output logic pi_select_o,
   output logic pi_read_o,
   output logic pi_write_o,
   output logic pi_done_o
);

   logic [3:0] w_cyc_nxt;
   logic       w_video_frame;
   logic       w_halted_frame;

   logic       w_video_on;
   logic       w_cpu_on;
   logic       w_video_sel_nxt;
   logic       w_video_ram_nxt;
   logic       w_video_rom_nxt;
   logic       w_cpu_en_nxt;
   logic       w_cpu_rd_nxt;
   logic       w_cpu_wr_nxt;

   pi_state_t  r_pi_state;
   pi_state_t  w_pi_state_nxt;
   logic [1:0] r_pi_phase;
   logic [1:0] w_pi_phase_nxt;
   logic       r_pi_rw;
   logic       w_pi_rw_nxt;
   logic       w_slot_go;
   logic       w_pi_start;
   logic       w_pi_sel_nxt;
   logic       w_pi_rd_nxt;
   logic       w_pi_wr_nxt;
   logic       w_pi_done_nxt;

   logic       r_cpu_en;
   logic       r_cpu_rd;
   logic       r_cpu_wr;
   logic       r_video_sel;
   logic       r_video_ram;
   logic       r_video_rom;
   logic       r_pi_sel;
   logic       r_pi_rd;
   logic       r_pi_wr;
   logic       r_pi_done;

   bus_slot_counter u_slot_counter (
      .i_clk              (clk_sys_i),
      .i_rst_n            (reset_ni),
      .i_video_en         (video_en_i),
      .i_cpu_halted       (cpu_halted_i),
      .o_cyc_nxt          (w_cyc_nxt),
      .o_video_frame_nxt  (w_video_frame),
      .o_halted_frame_nxt (w_halted_frame),
      .o_clk8             (clk8_o),
      .o_phi2             (phi2_o)
   );

   // Video and CPU slot decode for the coming slot.
   always_comb begin
      w_video_on      = VIDEO_EN_DEFAULT && w_video_frame;
      w_cpu_on        = !w_halted_frame;
      w_video_sel_nxt = w_video_on && (w_cyc_nxt < CYC_PI_SLOT0);
      w_video_ram_nxt = w_video_on && (w_cyc_nxt == CYC_VID_RAM + 4'd1);
      w_video_rom_nxt = w_video_on && (w_cyc_nxt == CYC_VID_ROM + 4'd1);
      w_cpu_en_nxt    = w_cpu_on && (w_cyc_nxt >= CYC_CPU);
      w_cpu_rd_nxt    = w_cpu_on && (w_cyc_nxt >= CYC_CPU + 4'd1) && bus_rw_ni;
      // Write strobe drops one slot early so data is held past the strobe.
      w_cpu_wr_nxt    = w_cpu_on && (w_cyc_nxt >= CYC_CPU + 4'd2) &&
                        (w_cyc_nxt <= 4'd14) && !bus_rw_ni;
   end

   // RPi FSM state register.
   always_ff @(posedge clk_sys_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_pi_state <= IDLE;
         r_pi_phase <= 2'd0;
         r_pi_rw    <= 1'b1;
      end else begin
         r_pi_state <= w_pi_state_nxt;
         r_pi_phase <= w_pi_phase_nxt;
         r_pi_rw    <= w_pi_rw_nxt;
      end
   end

   // RPi FSM next state; a request seen at the edge before a slot wins it.
   always_comb begin
      w_slot_go      = (w_cyc_nxt == CYC_PI_SLOT0) ||
                       (PI_TURBO && w_halted_frame && (w_cyc_nxt == CYC_PI_SLOT1));
      w_pi_start     = pi_pending_i && w_slot_go;
      w_pi_state_nxt = r_pi_state;
      w_pi_phase_nxt = r_pi_phase;
      w_pi_rw_nxt    = r_pi_rw;
      case (r_pi_state)
         IDLE, ARMED: begin
            if (w_pi_start) begin
               w_pi_state_nxt = ACCESS;
               w_pi_phase_nxt = 2'd0;
               w_pi_rw_nxt    = pi_rw_ni;
            end else if (pi_pending_i) begin
               w_pi_state_nxt = ARMED;
            end else begin
               w_pi_state_nxt = IDLE;
            end
         end
         ACCESS: begin
            if (r_pi_phase == 2'd2) begin
               w_pi_state_nxt = DONE;
               w_pi_phase_nxt = 2'd0;
            end else begin
               w_pi_phase_nxt = r_pi_phase + 2'd1;
            end
         end
         DONE: begin
            if (!pi_pending_i) begin
               w_pi_state_nxt = IDLE;
            end else begin
               w_pi_state_nxt = DONE;
            end
         end
         default: begin
            w_pi_state_nxt = IDLE;
            w_pi_phase_nxt = 2'd0;
         end
      endcase
   end

   // RPi FSM outputs: select for setup/strobe/hold, done once the hold slot ends.
   always_comb begin
      w_pi_sel_nxt  = (w_pi_state_nxt == ACCESS);
      w_pi_rd_nxt   = w_pi_sel_nxt && (w_pi_phase_nxt == 2'd1) && w_pi_rw_nxt;
      w_pi_wr_nxt   = w_pi_sel_nxt && (w_pi_phase_nxt == 2'd1) && !w_pi_rw_nxt;
      w_pi_done_nxt = (r_pi_state == ACCESS) && (w_pi_state_nxt == DONE);
   end

   // Output registers.
   always_ff @(posedge clk_sys_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_cpu_en    <= 1'b0;
         r_cpu_rd    <= 1'b0;
         r_cpu_wr    <= 1'b0;
         r_video_sel <= 1'b0;
         r_video_ram <= 1'b0;
         r_video_rom <= 1'b0;
         r_pi_sel    <= 1'b0;
         r_pi_rd     <= 1'b0;
         r_pi_wr     <= 1'b0;
         r_pi_done   <= 1'b0;
      end else begin
         r_cpu_en    <= w_cpu_en_nxt;
         r_cpu_rd    <= w_cpu_rd_nxt;
         r_cpu_wr    <= w_cpu_wr_nxt;
         r_video_sel <= w_video_sel_nxt;
         r_video_ram <= w_video_ram_nxt;
         r_video_rom <= w_video_rom_nxt;
         r_pi_sel    <= w_pi_sel_nxt;
         r_pi_rd     <= w_pi_rd_nxt;
         r_pi_wr     <= w_pi_wr_nxt;
         r_pi_done   <= w_pi_done_nxt;
      end
   end

   assign cpu_enable_o       = r_cpu_en;
   assign cpu_read_o         = r_cpu_rd;
   assign cpu_write_o        = r_cpu_wr;
   assign video_select_o     = r_video_sel;
   assign video_ram_strobe_o = r_video_ram;
   assign video_rom_strobe_o = r_video_rom;
   assign pi_select_o        = r_pi_sel;
   assign pi_read_o          = r_pi_rd;
   assign pi_write_o         = r_pi_wr;
   assign pi_done_o          = r_pi_done;

   bus_sched_checker u_checker (
      .i_clk       (clk_sys_i),
      .i_rst_n     (reset_ni),
      .i_video_sel (r_video_sel),
      .i_pi_sel    (r_pi_sel),
      .i_cpu_en    (r_cpu_en)
   );

endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler: directed steps plus random traffic,
// compared every cycle against a frame/slot reference model.
`timescale 1ns/1ps
module tb_bus_scheduler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic video_en = 1'b1;
   logic halted = 1'b0;
   logic brw = 1'b1;
   logic pend = 1'b0;
   logic prw = 1'b1;
   logic clk8_o, phi2_o, cpu_enable_o, cpu_read_o, cpu_write_o;
   logic video_select_o, video_ram_strobe_o, video_rom_strobe_o;
   logic pi_select_o, pi_read_o, pi_write_o, pi_done_o;

   int checks = 0;
   int errors = 0;

   // reference model: slot index, frame flags, and the RPi access as absolute times
   int m_cyc, m_n, m_start, m_done_at;
   bit m_rst, m_vflag, m_hflag, m_busy, m_wait_low, m_rw, m_brw;
   int cnt_a, cnt_b;

   bus_scheduler dut (
      .clk_sys_i          (clk),
      .reset_ni           (rst_n),
      .video_en_i         (video_en),
      .cpu_halted_i       (halted),
      .bus_rw_ni          (brw),
      .pi_pending_i       (pend),
      .pi_rw_ni           (prw),
      .clk8_o             (clk8_o),
      .phi2_o             (phi2_o),
      .cpu_enable_o       (cpu_enable_o),
      .cpu_read_o         (cpu_read_o),
      .cpu_write_o        (cpu_write_o),
      .video_select_o     (video_select_o),
      .video_ram_strobe_o (video_ram_strobe_o),
      .video_rom_strobe_o (video_rom_strobe_o),
      .pi_select_o        (pi_select_o),
      .pi_read_o          (pi_read_o),
      .pi_write_o         (pi_write_o),
      .pi_done_o          (pi_done_o)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] observed();
      return {clk8_o, phi2_o, cpu_enable_o, cpu_read_o, cpu_write_o, video_select_o,
              video_ram_strobe_o, video_rom_strobe_o, pi_select_o, pi_read_o,
              pi_write_o, pi_done_o};
   endfunction

   function automatic logic [11:0] expected();
      logic [11:0] e;
      int off;
      bit von, con;
      e = 12'h000;
      if (!m_rst) begin
         von   = m_vflag;
         con   = !m_hflag;
         off   = m_n - m_start;
         e[11] = (m_cyc % 2) == 1;
         e[10] = m_cyc >= 8;
         e[9]  = con && m_cyc >= 8;
         e[8]  = con && m_cyc >= 9 && m_brw;
         e[7]  = con && m_cyc >= 10 && m_cyc <= 14 && !m_brw;
         e[6]  = von && m_cyc <= 4;
         e[5]  = von && m_cyc == 1;
         e[4]  = von && m_cyc == 3;
         e[3]  = m_busy && off <= 2;
         e[2]  = m_busy && off == 1 && m_rw;
         e[1]  = m_busy && off == 1 && !m_rw;
         e[0]  = (m_done_at == m_n);
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rst = 1'b1; m_cyc = 0; m_n = 0; m_start = -100; m_done_at = -1;
      m_vflag = 1'b0; m_hflag = 1'b0; m_busy = 1'b0; m_wait_low = 1'b0;
      m_rw = 1'b1; m_brw = 1'b0;
   endtask

   // one clock edge of the reference model, using the inputs present at that edge
   task automatic model_edge();
      bit slot;
      if (m_cyc == 15) begin
         m_vflag = video_en;
         m_hflag = halted;
      end
      m_cyc = (m_cyc + 1) % 16;
      m_n++;
      m_brw = brw;
      slot = (m_cyc == 5) || (m_hflag && m_cyc == 12);
      if (m_wait_low) begin
         if (!pend) m_wait_low = 1'b0;
      end else if (m_busy) begin
         if (m_n - m_start == 3) begin
            m_busy = 1'b0;
            m_wait_low = 1'b1;
            m_done_at = m_n;
         end
      end else if (pend && slot) begin
         m_busy = 1'b1;
         m_start = m_n;
         m_rw = prw;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check("cycle_outputs", {20'h0, observed()}, {20'h0, expected()});
   endtask

   task automatic align_to(input int c);
      for (int g = 0; g < 20 && m_cyc != c; g++) tick();
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_state", {20'h0, observed()}, 32'h0);
      rst_n = 1'b1;
      m_rst = 1'b0;

      // idle frames with video enabled
      repeat (33) tick();
      align_to(15);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt_a += int'(video_select_o);
         cnt_b += int'(phi2_o && cpu_enable_o);
      end
      check("video_sel_count", cnt_a, 5);
      check("phi2_cpu_count", cnt_b, 8);

      // single read request held high for three frames
      align_to(2);
      pend = 1'b1; prw = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 48; i++) begin
         tick();
         cnt_a += int'(pi_read_o);
         cnt_b += int'(pi_done_o);
      end
      check("one_read_held", cnt_a, 1);
      check("one_done_held", cnt_b, 1);
      pend = 1'b0;
      tick();

      // request rising in the slot cycle waits a frame
      align_to(5);
      pend = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt_a += int'(pi_select_o);
      end
      check("late_req_sel", cnt_a, 1);
      repeat (3) tick();
      check("late_req_done", {31'h0, pi_done_o}, 32'h1);
      pend = 1'b0;
      repeat (2) tick();

      // halted CPU: two writes in one frame
      halted = 1'b1;
      align_to(15);
      pend = 1'b1; prw = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt_a += int'(pi_write_o);
         cnt_b += int'(cpu_enable_o);
         if (m_done_at == m_n) pend = 1'b0;
         else pend = 1'b1;
      end
      check("turbo_writes", cnt_a, 2);
      check("turbo_cpu_off", cnt_b, 0);
      pend = 1'b0; halted = 1'b0; prw = 1'b1;

      // CPU write then read frames
      tick();
      align_to(15);
      brw = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt_a += int'(cpu_write_o);
         cnt_b += int'(cpu_read_o);
      end
      check("cpu_write_count", cnt_a, 5);
      check("cpu_write_noread", cnt_b, 0);
      brw = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt_a += int'(cpu_read_o);
      end
      check("cpu_read_count", cnt_a, 7);

      // reset in the middle of an RPi write
      align_to(0);
      pend = 1'b1; prw = 1'b0;
      align_to(6);
      check("write_before_rst", {31'h0, pi_write_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("async_reset", {20'h0, observed()}, 32'h0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_rst = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cnt_a += int'(pi_done_o);
         cnt_b += int'(pi_select_o);
      end
      check("post_rst_done", cnt_a, 1);
      check("post_rst_sel", cnt_b, 3);
      pend = 1'b0;

      // random traffic
      for (int i = 0; i < 640; i++) begin
         tick();
         video_en = ($urandom % 4) != 0;
         if (($urandom % 16) == 0) halted = ~halted;
         brw = $urandom % 2;
         prw = $urandom % 2;
         if (($urandom % 5) == 0) pend = ~pend;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
